// File: rtl/k_band_energy_accum.sv
// Streaming spectral-energy accumulator: |x|^2 per complex bin, summed into bands of
// 2**LOG2_BAND bins, one bin per cycle in, one band energy per band out, full backpressure.
module k_band_energy_accum #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 40,
  parameter int LOG2_BAND = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*IN_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int SQ_W  = 2 * IN_WIDTH;
  localparam int SUM_W = SQ_W + 1;
  localparam int ACC_W = OUT_WIDTH + 1;
  localparam int CNT_W = (LOG2_BAND > 0) ? LOG2_BAND : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_BAND) - 1);

  logic                       en;
  logic                       s1_valid_q, s1_last_q;
  logic signed [IN_WIDTH-1:0] s1_re_q, s1_im_q;
  logic                       s2_valid_q, s2_last_q;
  logic [SQ_W-1:0]            s2_re2_q, s2_im2_q;
  logic                       s3_valid_q, s3_last_q;
  logic [SUM_W-1:0]           s3_sum_q;
  logic [OUT_WIDTH-1:0]       acc_q;
  logic [CNT_W-1:0]           bin_cnt_q;
  logic                       first_q, sat_q;
  logic [OUT_WIDTH-1:0]       out_data_q;
  logic                       out_valid_q, out_last_q, out_user_q;

  logic signed [SQ_W-1:0]     re_sq, im_sq;
  logic [OUT_WIDTH-1:0]       acc_base, acc_in_d;
  logic [ACC_W-1:0]           acc_wide;
  logic                       ovf, sat_d, close_d;

  // The whole pipeline advances only when the output register is free or draining.
  assign en            = !(out_valid_q && !m_axis_tready);
  assign s_axis_tready = en && !rst;

  // Both operands signed, so the product is a true signed square; it is never negative.
  assign re_sq = s1_re_q * s1_re_q;
  assign im_sq = s1_im_q * s1_im_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    acc_base = first_q ? '0 : acc_q;
    acc_wide = {1'b0, acc_base} + ACC_W'(s3_sum_q);
    ovf      = acc_wide[OUT_WIDTH];
    acc_in_d = ovf ? '1 : acc_wide[OUT_WIDTH-1:0];
    sat_d    = sat_q | ovf;
    close_d  = s3_last_q || (bin_cnt_q == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_re2_q    <= '0;
      s2_im2_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_sum_q    <= '0;
      acc_q       <= '0;
      bin_cnt_q   <= '0;
      first_q     <= 1'b1;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= s_axis_tvalid;
      s1_last_q  <= s_axis_tlast;
      s1_re_q    <= s_axis_tdata[2*IN_WIDTH-1:IN_WIDTH];
      s1_im_q    <= s_axis_tdata[IN_WIDTH-1:0];

      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_re2_q   <= re_sq;
      s2_im2_q   <= im_sq;

      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      s3_sum_q   <= {1'b0, s2_re2_q} + {1'b0, s2_im2_q};

      // With en high the output is either empty or being accepted this edge.
      out_valid_q <= s3_valid_q && close_d;
      if (s3_valid_q) begin
        if (close_d) begin
          out_data_q <= acc_in_d;
          out_user_q <= sat_d;
          out_last_q <= s3_last_q;
          bin_cnt_q  <= '0;
          first_q    <= 1'b1;
          sat_q      <= 1'b0;
        end else begin
          acc_q     <= acc_in_d;
          bin_cnt_q <= bin_cnt_q + 1'b1;
          first_q   <= 1'b0;
          sat_q     <= sat_d;
        end
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;

endmodule

// File: tb/tb_k_band_energy_accum.sv
// Scoreboard bench for k_band_energy_accum: a 40-bit and a 33-bit instance run in lockstep
// on shared stimulus; a behavioural band model predicts every output of both.
module tb_k_band_energy_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready, s_tready_s;
  logic        m_tready;
  logic [39:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [32:0] ms_tdata;
  logic        ms_tvalid, ms_tlast, ms_tuser;

  always #5 clk = ~clk;

  k_band_energy_accum #(.IN_WIDTH(16), .OUT_WIDTH(40), .LOG2_BAND(2)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
  );

  k_band_energy_accum #(.IN_WIDTH(16), .OUT_WIDTH(33), .LOG2_BAND(2)) dut_s (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_s),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(ms_tdata), .m_axis_tvalid(ms_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(ms_tlast), .m_axis_tuser(ms_tuser)
  );

  typedef struct packed {
    logic [39:0] data;
    logic        last;
    logic        user;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_pass = 0;
  int   n_checks = 0;
  int   stall_cnt = 0;
  bit   rand_ready = 1'b0;

  longint unsigned m_acc[2];
  bit              m_sat[2];
  int              m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_sat[k] = 1'b0;
    end
  endtask

  // Band model for both output widths: saturating sum, sticky flag, close on count or tlast.
  task automatic model_bin(input logic [15:0] re, input logic [15:0] im, input logic last);
    longint e;
    e = longint'($signed(re)) * longint'($signed(re)) + longint'($signed(im)) * longint'($signed(im));
    for (int k = 0; k < 2; k++) begin
      longint unsigned lim;
      longint unsigned a;
      lim = (64'd1 << ((k == 0) ? 40 : 33)) - 1;
      a   = ((m_cnt == 0) ? 64'd0 : m_acc[k]) + longint'(e);
      if (a > lim) begin
        a        = lim;
        m_sat[k] = 1'b1;
      end
      m_acc[k] = a;
    end
    if (last || m_cnt == 3) begin
      q0.push_back('{data: m_acc[0][39:0], last: last, user: m_sat[0]});
      q1.push_back('{data: m_acc[1][39:0], last: last, user: m_sat[1]});
      m_cnt = 0;
      m_sat[0] = 1'b0;
      m_sat[1] = 1'b0;
    end else begin
      m_cnt++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_bin(input logic [15:0] re, input logic [15:0] im, input logic last);
    int tries;
    tries    = 0;
    s_tdata  = {re, im};
    s_tlast  = last;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        model_bin(re, im, last);
        @(posedge clk); #1;
        break;
      end
      tries++;
      stall_cnt++;
      if (tries > 500) begin
        check("accept_timeout", 1, 0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    s_tvalid = 1'b0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", q0.size() + q1.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_tuser", m_tuser, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_s_tready_33", s_tready_s, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_s_tready", s_tready, 1);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 m_tready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitors: hold checks while stalled, scoreboard compare on each handshake.
  logic [41:0] prev0, prev1;
  bit          ps0 = 1'b0, ps1 = 1'b0;
  exp_t        e0, e1;

  always @(negedge clk) begin
    if (rst) begin
      ps0 = 1'b0;
      ps1 = 1'b0;
    end else begin
      if (ps0) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_out", {m_tdata, m_tlast, m_tuser}, prev0);
      end
      if (ps1) begin
        check("hold_valid_33", ms_tvalid, 1);
        check("hold_out_33", {7'd0, ms_tdata, ms_tlast, ms_tuser}, prev1);
      end
      if (m_tvalid && m_tready) begin
        if (q0.size() == 0) check("spurious_out", 1, 0);
        else begin
          e0 = q0.pop_front();
          check("out_data", m_tdata, e0.data);
          check("out_last", m_tlast, e0.last);
          check("out_user", m_tuser, e0.user);
        end
      end
      if (ms_tvalid && m_tready) begin
        if (q1.size() == 0) check("spurious_out_33", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("out_data_33", ms_tdata, e1.data);
          check("out_last_33", ms_tlast, e1.last);
          check("out_user_33", ms_tuser, e1.user);
        end
      end
      ps0   = m_tvalid && !m_tready;
      ps1   = ms_tvalid && !m_tready;
      prev0 = {m_tdata, m_tlast, m_tuser};
      prev1 = {7'd0, ms_tdata, ms_tlast, ms_tuser};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Basic band with latency: (3,4) x4 -> 100, visible after the third edge.
    for (int i = 0; i < 4; i++) send_bin(16'd3, 16'd4, i == 3);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_e2_valid", m_tvalid, 0);
    @(posedge clk); #1;
    check("lat_e3_valid", m_tvalid, 1);
    drain();

    // Streaming: (1,-1) x16, no input stalls allowed.
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) send_bin(16'd1, 16'hFFFF, i == 15);
    check("stream_stalls", stall_cnt, 0);
    drain();

    // Short frame: (0,2) x6 -> 16 then partial 8 with tlast.
    for (int i = 0; i < 6; i++) send_bin(16'd0, 16'd2, i == 5);
    drain();

    // Saturation on the 33-bit instance, then a clean band.
    for (int i = 0; i < 4; i++) send_bin(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 4; i++) send_bin(16'd1, 16'd0, 1'b0);
    drain();

    // Random backpressure over 1000 random bins.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_bin(16'($urandom), 16'($urandom), $urandom_range(0, 6) == 0);
    end
    s_tvalid   = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk); #1;
    m_tready = 1'b1;
    drain();

    // Reset mid-band: partial band and in-flight bins vanish.
    for (int i = 0; i < 2; i++) send_bin(16'd5, 16'd5, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send_bin(16'd2, 16'd0, 1'b0);
    drain();

    idle(5);
    check("final_queue_empty", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
